// File: rtl/node_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// node_mem_stream_reader
//
// Reads a run of 16-bit halfwords from a memory with fixed read latency of
// one cycle and streams them out on an Avalon-ST source. A small
// first-word-fall-through FIFO decouples the memory from the stream sink.
// Reads are only issued when the FIFO is guaranteed to have room for them,
// so the FIFO can never overflow.
//
// Ports
//   clk, reset           single clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_addr, cmd_len    start halfword address and halfword count
//   m_address ...        memory read port (m_write/m_byteenable/m_clken fixed)
//   m_readdata           read data, valid the cycle after m_chipselect
//   st_data/st_valid/    stream source; st_sop marks the first word of a
//   st_ready/st_sop/     transfer and st_eop the last one
//   st_eop
//   busy                 high while a transfer is in progress
//   done                 one-cycle pulse: transfer finished (or zero length)
//   err                  one-cycle pulse: start address out of range
// ---------------------------------------------------------------------------
module node_mem_stream_reader #(
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned MEM_WORDS  = 20480,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    // Command interface
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    // Memory read port
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [1:0]        m_byteenable,
    output logic              m_clken,
    input  logic [15:0]       m_readdata,
    // Stream source
    output logic [15:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    // Status
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain
    } state_e;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] data;
    } entry_t;

    // Control state
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic              first_q, first_d;      // next issued read is the first one
    logic              infl_q, infl_d;        // read issued last cycle, data on m_readdata now
    logic              infl_sop_q, infl_sop_d;
    logic              infl_eop_q, infl_eop_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Output FIFO
    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic              addr_oob;
    logic [CntW-1:0]   occupancy;
    entry_t            head;

    // -----------------------------------------------------------------------
    // Datapath decode
    // -----------------------------------------------------------------------
    always_comb begin
        // Words already buffered plus the one still coming back from memory.
        occupancy = count_q + CntW'(infl_q);
        issue     = (state_q == StRead) && (occupancy < CntW'(FIFO_DEPTH)) &&
                    (remain_q != '0);
        push      = infl_q;
        head      = mem_q[rd_ptr_q];
        pop       = (count_q != '0) && st_ready;
        addr_oob  = (32'(cmd_addr) >= MEM_WORDS);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        first_d    = first_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        infl_d     = issue;
        infl_sop_d = issue && first_q;
        infl_eop_d = issue && (remain_q == LEN_W'(1));

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (addr_oob) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d   = cmd_addr;
                        remain_d = cmd_len;
                        first_d  = 1'b1;
                        state_d  = StRead;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    if (addr_q == ADDR_W'(MEM_WORDS - 1)) begin
                        addr_d = '0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    remain_d = remain_q - LEN_W'(1);
                    first_d  = 1'b0;
                    if (remain_q == LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // The eop word is the last one of the transfer: once it leaves
                // the FIFO nothing is buffered and nothing is in flight.
                if (pop && head.eop && (count_q == CntW'(1)) && !infl_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO next-state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{sop: infl_sop_q, eop: infl_eop_q, data: m_readdata};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            first_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_sop_q <= 1'b0;
            infl_eop_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            first_q    <= first_d;
            infl_q     <= infl_d;
            infl_sop_q <= infl_sop_d;
            infl_eop_q <= infl_eop_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: st_valid masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        cmd_ready    = (state_q == StIdle);
        m_address    = addr_q;
        m_chipselect = issue;
        m_write      = 1'b0;
        m_byteenable = 2'b11;
        m_clken      = 1'b1;
        st_valid     = (count_q != '0);
        st_data      = head.data;
        st_sop       = st_valid && head.sop;
        st_eop       = st_valid && head.eop;
        busy         = (state_q != StIdle);
        done         = done_q;
        err          = err_q;
    end

endmodule

// File: tb/tb_node_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// Bench for node_mem_stream_reader. A behavioural memory with one cycle of
// read latency feeds the DUT; expected beats and read addresses are queued
// when each command is driven and consumed as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_node_mem_stream_reader;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned MEM_WORDS  = 20480;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [1:0]        m_byteenable;
    logic              m_clken;
    logic [15:0]       m_readdata = 16'h0;
    logic [15:0]       st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;
    logic              busy;
    logic              done;
    logic              err;

    node_mem_stream_reader #(
        .ADDR_W    (ADDR_W),
        .MEM_WORDS (MEM_WORDS),
        .LEN_W     (LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write     (m_write),
        .m_byteenable(m_byteenable),
        .m_clken     (m_clken),
        .m_readdata  (m_readdata),
        .st_data     (st_data),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_sop      (st_sop),
        .st_eop      (st_eop),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Memory contents: 0x100..0x107 hold 0xA000..0xA007, elsewhere a pattern.
    function automatic logic [15:0] memf(input logic [14:0] a);
        if (a >= 15'h100 && a <= 15'h107) begin
            return 16'hA000 | {13'd0, a[2:0]};
        end
        return {1'b0, a} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (m_chipselect) m_readdata <= memf(m_address);
    end

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        int addr;
        int len;
        int mode;       // 0: st_ready high, 1: low for 20 cycles, 2: random
        int exp_done;
        int exp_err;
        int exp_reads;
    } vec_t;

    beat_t       exp_q[$];
    int          addr_exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          cyc, cs_cnt, done_cnt, err_cnt, beat_cnt;
    int          first_valid_cyc, last_beat_cyc, done_cyc;
    logic        hold_v;
    logic [17:0] hold_val;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; cs_cnt = 0; done_cnt = 0; err_cnt = 0; beat_cnt = 0;
        first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        hold_v = 1'b0; hold_val = '0;
    endtask

    // Called at a falling edge after st_ready has been set for the next edge.
    task automatic mon_cycle();
        beat_t e;
        if (m_chipselect) begin
            cs_cnt++;
            if (addr_exp_q.size() == 0) begin
                chk("unexpected m_chipselect", m_chipselect, 0);
            end else begin
                chk("m_address", m_address, addr_exp_q.pop_front());
            end
        end
        if (hold_v) begin
            chk("st_valid held", st_valid, 1);
            chk("st payload held", {st_sop, st_eop, st_data}, hold_val);
        end
        if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (st_valid && st_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected beat", st_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("st_data", st_data, e.data);
                chk("st_sop", st_sop, e.sop);
                chk("st_eop", st_eop, e.eop);
            end
            beat_cnt++;
            last_beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy low at done", busy, 0);
            chk("cmd_ready at done", cmd_ready, 1);
        end
        if (err) begin
            err_cnt++;
            chk("busy low at err", busy, 0);
        end
        hold_v   = st_valid && !st_ready;
        hold_val = {st_sop, st_eop, st_data};
        cyc++;
    endtask

    task automatic push_expect(input int addr, input int len);
        int a;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % MEM_WORDS;
            addr_exp_q.push_back(a);
            exp_q.push_back('{data: memf(15'(a)), sop: (i == 0), eop: (i == len - 1)});
        end
    endtask

    task automatic drive_cmd(input int addr, input int len, input int mode);
        @(negedge clk);
        chk("cmd_ready before command", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        st_ready  = (mode != 1);
        if (len != 0 && addr < int'(MEM_WORDS)) push_expect(addr, len);
        clear_stats();
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int post;
        post = -1;
        drive_cmd(v.addr, v.len, v.mode);
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            case (v.mode)
                1:       st_ready = (it >= 20);
                2:       st_ready = (post >= 0) || ($urandom_range(0, 3) != 0);
                default: st_ready = 1'b1;
            endcase
            mon_cycle();
            if (it == 0) chk("busy after accept", busy, (v.exp_reads > 0));
            if (v.mode == 1 && it == 19) begin
                chk("reads issued while stalled", cs_cnt, FIFO_DEPTH);
                chk("st_valid while stalled", st_valid, 1);
            end
            if (post < 0 && (done_cnt + err_cnt) > 0) post = it;
            if (post >= 0 && it >= post + 3) break;
        end
        chk("done pulses", done_cnt, v.exp_done);
        chk("err pulses", err_cnt, v.exp_err);
        chk("reads issued", cs_cnt, v.exp_reads);
        chk("beats delivered", beat_cnt, v.exp_reads);
        chk("beats outstanding", exp_q.size(), 0);
        chk("addresses outstanding", addr_exp_q.size(), 0);
        if (v.exp_reads == 0 && v.exp_done + v.exp_err > 0) begin
            chk("pulse latency", (v.exp_done != 0) ? done_cyc : 0, 0);
        end
        if (v.exp_reads > 0) chk("done after last beat", done_cyc, last_beat_cyc + 1);
        if (v.exp_reads > 0 && v.mode == 0) begin
            chk("first st_valid latency", first_valid_cyc, 2);
            chk("done cycle at full rate", done_cyc, v.len + 2);
        end
        exp_q.delete();
        addr_exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        chk({tag, " m_chipselect"}, m_chipselect, 0);
        chk({tag, " st_valid"}, st_valid, 0);
        chk({tag, " st_sop"}, st_sop, 0);
        chk({tag, " st_eop"}, st_eop, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " m_address"}, m_address, 0);
        chk({tag, " m_write"}, m_write, 0);
        chk({tag, " m_byteenable"}, m_byteenable, 2'b11);
        chk({tag, " m_clken"}, m_clken, 1);
    endtask

    initial begin
        //          addr   len mode done err reads
        vecs[0] = '{'h100,   8, 0,   1,   0,   8};
        vecs[1] = '{'h100,   8, 1,   1,   0,   8};
        vecs[2] = '{20478,   4, 0,   1,   0,   4};
        vecs[3] = '{5,       0, 0,   1,   0,   0};
        vecs[4] = '{20480,   3, 0,   0,   1,   0};
        vecs[5] = '{'h200,   1, 0,   1,   0,   1};
        vecs[6] = '{'h300,  13, 2,   1,   0,  13};
        vecs[7] = '{20479,   2, 2,   1,   0,   2};
        vecs[8] = '{32767,   5, 0,   0,   1,   0};
        vecs[9] = '{'h100,   8, 0,   1,   0,   8};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        st_ready  = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a transfer, after three beats.
        drive_cmd('h100, 8, 0);
        for (int it = 0; it < 50 && beat_cnt < 3; it++) begin
            @(negedge clk);
            st_ready = 1'b1;
            mon_cycle();
        end
        chk("beats before reset", beat_cnt, 3);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid reset");
        reset = 1'b0;
        exp_q.delete();
        addr_exp_q.delete();
        // Data of the read that was in flight at reset must not appear.
        for (int it = 0; it < 8; it++) begin
            @(negedge clk);
            chk("st_valid after reset", st_valid, 0);
            chk("done after reset", done, 0);
            chk("m_chipselect after reset", m_chipselect, 0);
        end

        run_vec(vecs[9]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/node_mem_stream_reader.md
NODE_MEM_STREAM_READER -- requirements
Module: node_mem_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, halfword address width of the memory port.
REQ-002 SHALL have parameter MEM_WORDS, default 20480, number of 16-bit words addressable.
REQ-003 SHALL have parameter LEN_W, default 16, transfer length width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1: command request.
REQ-008 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid & cmd_ready.
REQ-009 SHALL have port cmd_addr, input, ADDR_W: start halfword address.
REQ-010 SHALL have port cmd_len, input, LEN_W: number of halfwords to read.
REQ-011 SHALL have port m_address, output, ADDR_W: memory read address.
REQ-012 SHALL have port m_chipselect, output, 1: read strobe.
REQ-013 SHALL have port m_write, output, 1: held 0 at all times.
REQ-014 SHALL have port m_byteenable, output, 2: held 2'b11 at all times.
REQ-015 SHALL have port m_clken, output, 1: held 1 at all times.
REQ-016 SHALL have port m_readdata, input, 16: memory read data, fixed latency 1.
REQ-017 SHALL have port st_data, output, 16: stream data.
REQ-018 SHALL have ports st_valid (output, 1), st_ready (input, 1), st_sop (output, 1), st_eop (output, 1): Avalon-ST source.
REQ-019 SHALL have ports busy (output, 1), done (output, 1 pulse), err (output, 1 pulse).

Function
REQ-020 SHALL implement states IDLE, READ, DRAIN; cmd_ready=1 only in IDLE.
REQ-021 In IDLE, accepted command with cmd_len=0: no memory access, done pulses next cycle, stay IDLE.
REQ-022 In IDLE, accepted command with cmd_addr>=MEM_WORDS: no access, err pulses next cycle, stay IDLE.
REQ-023 Otherwise SHALL latch address/remaining count and enter READ next cycle.
REQ-024 In READ, SHALL assert m_chipselect in a cycle only if fifo_count + inflight < FIFO_DEPTH, where inflight = read issued in previous cycle.
REQ-025 Word returned on m_readdata SHALL be written to the FIFO exactly one cycle after its m_chipselect cycle.
REQ-026 Address SHALL increment by 1 per issued read, wrapping MEM_WORDS-1 -> 0.
REQ-027 After last read issued, SHALL enter DRAIN; DRAIN -> IDLE when FIFO empty, no inflight, and final word handshaked; done pulses in the cycle of that IDLE entry.
REQ-028 st_valid SHALL equal FIFO non-empty; word popped when st_valid & st_ready; st_data is FIFO head (first-word-fall-through).
REQ-029 st_sop SHALL be 1 with first word of a transfer, st_eop with last word; both with st_valid; single-word transfer has both set.
REQ-030 st_data/st_sop/st_eop SHALL hold stable while st_valid & ~st_ready.
REQ-031 Simultaneous FIFO push and pop SHALL keep count unchanged; FIFO never overflows; no word dropped or duplicated.
REQ-032 busy SHALL be 1 in READ and DRAIN, 0 in IDLE.
REQ-033 Throughput SHALL be one word per cycle with st_ready held high after initial 2-cycle latency (accept -> first st_valid).

Reset
REQ-034 Reset SHALL force IDLE, clear FIFO, inflight, counters; outputs: cmd_ready=1, m_chipselect=0, st_valid=0, st_sop=0, st_eop=0, busy=0, done=0, err=0, m_address=0.
REQ-035 Reset mid-transfer SHALL abandon it without done; read data returning the cycle after reset SHALL be discarded.

Verification
REQ-036 Memory halfwords 0x100..0x107 = 0xA000..0xA007, cmd addr 0x100 len 8, st_ready=1 -> 8 beats 0xA000..0xA007, sop on 1st, eop on 8th, done 1 cycle after last beat.
REQ-037 Same command, st_ready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, then stall; on release all 8 words in order, none lost.
REQ-038 cmd addr 20478 len 4 -> m_address sequence 20478, 20479, 0, 1.
REQ-039 cmd len 0 -> done pulse, no m_chipselect; cmd addr 20480 -> err pulse, no m_chipselect.
REQ-040 len 1 -> single beat with sop=eop=1.
REQ-041 reset asserted after 3 beats of a len-8 transfer -> all outputs at reset values, no done, next command runs normally.
